// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: RAM command codes,
// arbiter FSM states and a request-decode helper.
package mem_port_arbiter_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Only MREAD/MWRITE are requests; code 11 is treated as no request.
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and RAM-side signals of mem_port_arbiter.
//   p0_* / p1_* : command, address, write data, lock in; grant, read valid,
//                 read data out (from the arbiter's point of view)
//   mem_*       : command, address, write data out to RAM; read data in
// Modports: slave = arbiter view, master = requester/RAM view.
interface mem_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
) ();

  logic [1:0]    p0_cmd;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_lock;
  logic          p0_gnt;
  logic          p0_rvalid;
  logic [DW-1:0] p0_rdata;

  logic [1:0]    p1_cmd;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_lock;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [DW-1:0] p1_rdata;

  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  p0_cmd, p0_addr, p0_wdata, p0_lock,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_cmd, p1_addr, p1_wdata, p1_lock,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_cmd, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_cmd, p0_addr, p0_wdata, p0_lock,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_cmd, p1_addr, p1_wdata, p1_lock,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_cmd, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// arb_rr2: combinational 2-way round-robin pick.
//   req      : raw request per port
//   mask     : ports excluded from this pick
//   lock_vld : a lock owner exists and is still requesting
//   lock_id  : lock owner port
//   last_id  : port granted most recently (loses a tie)
//   win_vld  : a port was picked
//   win_id   : picked port
module arb_rr2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       lock_vld,
  input  logic       lock_id,
  input  logic       last_id,
  output logic       win_vld,
  output logic       win_id
);

  logic [1:0] cand;

  always_comb begin
    cand = req & ~mask;
    if (lock_vld) begin
      cand = cand & (lock_id ? 2'b10 : 2'b01);
    end
    win_vld = |cand;
    win_id  = 1'b0;
    case (cand)
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = ~last_id;
      default: win_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between port 0 (CPU) and
// port 1 (I/O / loader). Round-robin with optional bounded lock, registered
// RAM-side outputs, fixed read latency RD_LAT.
//   clk, reset : clock; synchronous active-low reset
//   bus        : requester and RAM signals (slave modport)
//   busy       : FSM not in IDLE
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output logic                 busy
);

  arb_state_t    state_q, state_d;
  logic [1:0]    lat_q, lat_d;
  logic          last_q;
  logic          rd_port_q;
  logic          own_vld_q, own_vld_d;
  logic          own_id_q, own_id_d;
  logic [3:0]    lock_cnt_q, lock_cnt_d;
  logic [3:0]    lock_base, lock_next;

  logic [1:0]    req_raw, mask;
  logic          owner_active;
  logic          arb_en, grant, cap;
  logic          win_vld, win_id, win_lock, other_req;
  logic [1:0]    win_cmd;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  assign req_raw      = {is_req(bus.p1_cmd), is_req(bus.p0_cmd)};
  assign owner_active = own_vld_q && req_raw[own_id_q];
  assign busy         = (state_q != IDLE);

  // Arbitration happens in IDLE, RESP and write ISSUE cycles; in a write
  // ISSUE the port being granted still shows its old request, so mask it.
  always_comb begin
    arb_en = 1'b0;
    mask   = '0;
    case (state_q)
      IDLE, RESP: arb_en = 1'b1;
      ISSUE: begin
        if (bus.mem_cmd != MREAD) begin
          arb_en = 1'b1;
          mask   = {bus.p1_gnt, bus.p0_gnt};
        end
      end
      default: arb_en = 1'b0;
    endcase
  end

  arb_rr2 u_arb (
    .req      (req_raw),
    .mask     (mask),
    .lock_vld (owner_active),
    .lock_id  (own_id_q),
    .last_id  (last_q),
    .win_vld  (win_vld),
    .win_id   (win_id)
  );

  assign grant     = arb_en && win_vld;
  assign win_cmd   = win_id ? bus.p1_cmd   : bus.p0_cmd;
  assign win_addr  = win_id ? bus.p1_addr  : bus.p0_addr;
  assign win_wdata = win_id ? bus.p1_wdata : bus.p0_wdata;
  assign win_lock  = win_id ? bus.p1_lock  : bus.p0_lock;
  assign other_req = win_id ? (req_raw[0] && !mask[0]) : (req_raw[1] && !mask[1]);
  // Last RWAIT cycle: RAM data is valid now and is latched for RESP.
  assign cap       = (state_q == RWAIT) && (lat_q == 2'd0);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: state_d = grant ? ISSUE : IDLE;
      ISSUE: begin
        if (bus.mem_cmd == MREAD) begin
          state_d = RWAIT;
          lat_d   = 2'(RD_LAT - 1);
        end else begin
          state_d = grant ? ISSUE : IDLE;
        end
      end
      RWAIT: begin
        if (lat_q == 2'd0) state_d = RESP;
        else               lat_d   = lat_q - 2'd1;
      end
      RESP: state_d = grant ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lock bookkeeping. An idle owner loses the lock at the arbitration point;
  // grants to the owner while the other port waits are counted, and reaching
  // MAX_LOCK drops the lock so round-robin hands the next pick to the other.
  always_comb begin
    own_vld_d  = own_vld_q;
    own_id_d   = own_id_q;
    lock_cnt_d = lock_cnt_q;
    lock_base  = (own_vld_q && (own_id_q == win_id)) ? lock_cnt_q : 4'd0;
    lock_next  = lock_base + 4'd1;
    if (arb_en && own_vld_q && !req_raw[own_id_q]) begin
      own_vld_d  = 1'b0;
      lock_cnt_d = '0;
    end
    if (grant) begin
      if (!win_lock) begin
        own_vld_d  = 1'b0;
        lock_cnt_d = '0;
      end else if (other_req) begin
        if (lock_next == 4'(MAX_LOCK)) begin
          own_vld_d  = 1'b0;
          lock_cnt_d = '0;
        end else begin
          own_vld_d  = 1'b1;
          own_id_d   = win_id;
          lock_cnt_d = lock_next;
        end
      end else begin
        own_vld_d  = 1'b1;
        own_id_d   = win_id;
        lock_cnt_d = lock_base;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      lat_q         <= '0;
      last_q        <= 1'b1;
      rd_port_q     <= 1'b0;
      own_vld_q     <= 1'b0;
      own_id_q      <= 1'b0;
      lock_cnt_q    <= '0;
      bus.mem_cmd   <= MNONE;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.p0_gnt    <= 1'b0;
      bus.p1_gnt    <= 1'b0;
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rdata  <= '0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      own_vld_q     <= own_vld_d;
      own_id_q      <= own_id_d;
      lock_cnt_q    <= lock_cnt_d;
      bus.p0_gnt    <= grant && !win_id;
      bus.p1_gnt    <= grant && win_id;
      bus.mem_cmd   <= grant ? win_cmd : MNONE;
      if (grant) begin
        bus.mem_addr  <= win_addr;
        bus.mem_wdata <= win_wdata;
        last_q        <= win_id;
        rd_port_q     <= win_id;
      end
      bus.p0_rvalid <= cap && !rd_port_q;
      bus.p1_rvalid <= cap && rd_port_q;
      if (cap && !rd_port_q) bus.p0_rdata <= bus.mem_rdata;
      if (cap && rd_port_q)  bus.p1_rdata <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy1, busy3;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(9), .DW(16)) bus1 ();
  mem_port_arbiter_if #(.AW(9), .DW(16)) bus3 ();

  mem_port_arbiter #(.AW(9), .DW(16), .RD_LAT(1), .MAX_LOCK(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1),
    .busy  (busy1)
  );

  mem_port_arbiter #(.AW(9), .DW(16), .RD_LAT(3), .MAX_LOCK(4)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3),
    .busy  (busy3)
  );

  // RAM models: fixed contents; DEAD whenever data is not due, so a capture
  // in the wrong cycle shows up as a wrong value.
  function automatic logic [15:0] rom(input logic [8:0] a);
    case (a)
      9'h010:  return 16'hBEEF;
      9'h020:  return 16'h1234;
      default: return 16'h0000;
    endcase
  endfunction

  logic [15:0] d3a, d3b;
  always @(posedge clk) begin
    bus1.mem_rdata <= (bus1.mem_cmd == MREAD) ? rom(bus1.mem_addr) : 16'hDEAD;
    d3a            <= (bus3.mem_cmd == MREAD) ? rom(bus3.mem_addr) : 16'hDEAD;
    d3b            <= d3a;
    bus3.mem_rdata <= d3b;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.p0_cmd = MNONE; bus1.p0_addr = '0; bus1.p0_wdata = '0; bus1.p0_lock = 1'b0;
    bus1.p1_cmd = MNONE; bus1.p1_addr = '0; bus1.p1_wdata = '0; bus1.p1_lock = 1'b0;
    bus3.p0_cmd = MNONE; bus3.p0_addr = '0; bus3.p0_wdata = '0; bus3.p0_lock = 1'b0;
    bus3.p1_cmd = MNONE; bus3.p1_addr = '0; bus3.p1_wdata = '0; bus3.p1_lock = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p1_gnts;
    bit got;

    // ---- reset state + test 1: single p0 read, RD_LAT=1
    do_reset();
    check_eq("rst p0_gnt",    32'(bus1.p0_gnt),    32'd0);
    check_eq("rst p0_rvalid", 32'(bus1.p0_rvalid), 32'd0);
    check_eq("rst mem_cmd",   32'(bus1.mem_cmd),   32'd0);
    check_eq("rst mem_addr",  32'(bus1.mem_addr),  32'd0);
    check_eq("rst busy",      32'(busy1),          32'd0);

    bus1.p0_cmd = MREAD; bus1.p0_addr = 9'h010;
    tick(); // t+1
    check_eq("t1 p0_gnt",   32'(bus1.p0_gnt),   32'd1);
    check_eq("t1 mem_cmd",  32'(bus1.mem_cmd),  32'(MREAD));
    check_eq("t1 mem_addr", 32'(bus1.mem_addr), 32'h010);
    check_eq("t1 busy",     32'(busy1),         32'd1);
    tick(); // t+2
    bus1.p0_cmd = MNONE;
    check_eq("t1 rvalid t+2",  32'(bus1.p0_rvalid), 32'd0);
    check_eq("t1 mem_cmd t+2", 32'(bus1.mem_cmd),   32'd0);
    tick(); // t+3
    check_eq("t1 rvalid t+3", 32'(bus1.p0_rvalid), 32'd1);
    check_eq("t1 rdata",      32'(bus1.p0_rdata),  32'hBEEF);
    check_eq("t1 p1_rvalid",  32'(bus1.p1_rvalid), 32'd0);
    tick(); // t+4
    check_eq("t1 rvalid t+4", 32'(bus1.p0_rvalid), 32'd0);
    check_eq("t1 rdata hold", 32'(bus1.p0_rdata),  32'hBEEF);
    check_eq("t1 busy t+4",   32'(busy1),          32'd0);

    // ---- test 2: both ports write every cycle, grants alternate
    do_reset();
    bus1.p0_cmd = MWRITE; bus1.p0_addr = 9'h001; bus1.p0_wdata = 16'h1111;
    bus1.p1_cmd = MWRITE; bus1.p1_addr = 9'h002; bus1.p1_wdata = 16'h2222;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 6) begin
        bus1.p0_cmd = MNONE;
        bus1.p1_cmd = MNONE;
      end
      check_eq($sformatf("t2 p0_gnt %0d", i), 32'(bus1.p0_gnt), 32'(i % 2 == 0));
      check_eq($sformatf("t2 p1_gnt %0d", i), 32'(bus1.p1_gnt), 32'(i % 2 == 1));
      check_eq($sformatf("t2 mem_cmd %0d", i), 32'(bus1.mem_cmd), 32'(MWRITE));
      check_eq($sformatf("t2 mem_addr %0d", i), 32'(bus1.mem_addr),
               (i % 2 == 0) ? 32'h001 : 32'h002);
      check_eq($sformatf("t2 mem_wdata %0d", i), 32'(bus1.mem_wdata),
               (i % 2 == 0) ? 32'h1111 : 32'h2222);
    end
    tick();
    check_eq("t2 mem_cmd end", 32'(bus1.mem_cmd), 32'd0);
    check_eq("t2 gnt end",     32'({bus1.p1_gnt, bus1.p0_gnt}), 32'd0);
    check_eq("t2 busy end",    32'(busy1), 32'd0);

    // ---- test 3: p1 locked writes, p0 read waits for MAX_LOCK=4 grants
    do_reset();
    bus1.p0_cmd = MWRITE; bus1.p0_addr = 9'h003; bus1.p0_wdata = 16'h3333;
    tick();
    check_eq("t3 pre p0_gnt", 32'(bus1.p0_gnt), 32'd1);
    tick();
    bus1.p0_cmd = MREAD;  bus1.p0_addr = 9'h010;
    bus1.p1_cmd = MWRITE; bus1.p1_addr = 9'h004; bus1.p1_wdata = 16'h4444; bus1.p1_lock = 1'b1;
    p1_gnts = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (bus1.p1_gnt) p1_gnts++;
      if (bus1.p0_gnt) begin
        got = 1'b1;
        check_eq("t3 mem_cmd at p0 gnt", 32'(bus1.mem_cmd), 32'(MREAD));
      end
    end
    check_eq("t3 p0 granted",   32'(got),     32'd1);
    check_eq("t3 p1 gnt count", 32'(p1_gnts), 32'd4);
    tick();
    idle_inputs();
    tick();
    check_eq("t3 p0_rvalid", 32'(bus1.p0_rvalid), 32'd1);
    check_eq("t3 p0_rdata",  32'(bus1.p0_rdata),  32'hBEEF);

    // ---- test 4: reset during read wait drops the read
    do_reset();
    bus1.p0_cmd = MREAD; bus1.p0_addr = 9'h010; bus1.p0_wdata = 16'h5555;
    tick();
    check_eq("t4 p0_gnt", 32'(bus1.p0_gnt), 32'd1);
    tick();
    bus1.p0_cmd = MNONE;
    reset = 1'b0;
    tick();
    check_eq("t4 p0_gnt",    32'(bus1.p0_gnt),    32'd0);
    check_eq("t4 p0_rvalid", 32'(bus1.p0_rvalid), 32'd0);
    check_eq("t4 p0_rdata",  32'(bus1.p0_rdata),  32'd0);
    check_eq("t4 mem_cmd",   32'(bus1.mem_cmd),   32'd0);
    check_eq("t4 mem_addr",  32'(bus1.mem_addr),  32'd0);
    check_eq("t4 busy",      32'(busy1),          32'd0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("t4 no rvalid %0d", k), 32'(bus1.p0_rvalid), 32'd0);
    end

    // ---- test 5: p0 cmd=11 ignored while p1 read is served
    do_reset();
    bus1.p0_cmd = 2'b11;  bus1.p0_addr = 9'h1FF; bus1.p0_wdata = 16'h7777;
    bus1.p1_cmd = MREAD;  bus1.p1_addr = 9'h020;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 2) bus1.p1_cmd = MNONE;
      if (k == 5) bus1.p0_cmd = MNONE;
      check_eq($sformatf("t5 p0_gnt %0d", k),    32'(bus1.p0_gnt),    32'd0);
      check_eq($sformatf("t5 mem_cmd %0d", k),   32'(bus1.mem_cmd),   (k == 1) ? 32'(MREAD) : 32'd0);
      check_eq($sformatf("t5 p1_gnt %0d", k),    32'(bus1.p1_gnt),    32'(k == 1));
      check_eq($sformatf("t5 p1_rvalid %0d", k), 32'(bus1.p1_rvalid), 32'(k == 3));
    end
    check_eq("t5 p1_rdata",  32'(bus1.p1_rdata),  32'h1234);
    check_eq("t5 p0_rvalid", 32'(bus1.p0_rvalid), 32'd0);

    // ---- test 6: RD_LAT=3 build, p1 read
    do_reset();
    bus3.p1_cmd = MREAD; bus3.p1_addr = 9'h020;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) bus3.p1_cmd = MNONE;
      check_eq($sformatf("t6 p1_gnt %0d", k),    32'(bus3.p1_gnt),    32'(k == 1));
      check_eq($sformatf("t6 mem_cmd %0d", k),   32'(bus3.mem_cmd),   (k == 1) ? 32'(MREAD) : 32'd0);
      check_eq($sformatf("t6 p1_rvalid %0d", k), 32'(bus3.p1_rvalid), 32'(k == 5));
      if (k >= 2 && k <= 4) check_eq($sformatf("t6 busy %0d", k), 32'(busy3), 32'd1);
      if (k == 5) check_eq("t6 p1_rdata", 32'(bus3.p1_rdata), 32'h1234);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
